multadd_accum: RTL

Downstream consumer of the multiply-add stage. Accumulates each valid `prodsum` (qualified by `prodout`) over a fixed window of `WINDOW` samples and emits one windowed sum per window. Results are queued through a 2-entry buffer with a valid/ready handshake toward the next stage. The upstream stage has no backpressure, so overflow of the queue is detected and flagged, never stalled.

---
 rtl/multadd_pkg.sv | 23 ++
 rtl/multadd_res_fifo.sv | 71 +++++++
 rtl/multadd_accum.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/multadd_pkg.sv
// multadd_pkg: shared constants, FSM state type and helper for the windowed
// accumulator (multadd_accum) and its result queue (multadd_res_fifo).
package multadd_pkg;

    localparam int PRODSUM_W   = 17;
    localparam int DEF_WINDOW  = 4;
    localparam int DEF_ACC_W   = 20;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // Width of the in-window sample counter; at least one bit so WINDOW=1 still elaborates.
    function automatic int cnt_width(input int window);
        if (window > 1) begin
            return $clog2(window);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/multadd_res_fifo.sv
// multadd_res_fifo: 2-entry valid/ready result queue. Entry 0 is always the
// head, so the output data comes straight from a register and holds steady
// while the consumer stalls. A push into a full queue is only taken when a
// pop happens in the same cycle; otherwise it is ignored here and the
// caller reports the loss.
module multadd_res_fifo
    import multadd_pkg::*;
#(
    parameter int W = DEF_ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_data0;
    logic [W-1:0] r_data1;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push_ok;

    assign w_pop     = (r_cnt != 2'd0) && i_ready;
    assign w_push_ok = i_push && ((r_cnt != 2'd2) || w_pop);

    assign o_data  = r_data0;
    assign o_valid = (r_cnt != 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);

    // Shift-style storage: pops move entry 1 to the head, pushes fill the first free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= {W{1'b0}};
            r_data1 <= {W{1'b0}};
            r_cnt   <= 2'd0;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_data0 <= i_data;
                    end else begin
                        r_data1 <= i_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_data0 <= i_data;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= i_data;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: rtl/multadd_accum.sv
// multadd_accum: sums WINDOW qualified prodsum samples and queues one result
// per window through multadd_res_fifo. Upstream cannot be stalled, so a
// completed result meeting a full queue is dropped and flagged in drop_err.
// Optional feature macro: MULTADD_ACC_SAT_EN (saturating adds + sat_flag port).
module multadd_accum
    import multadd_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRODSUM_W-1:0] prodsum,
    input  logic                 prodout,
    input  logic                 clear,
    output logic [ACC_W-1:0]     sum_out,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 busy,
    output logic                 drop_err
`ifdef MULTADD_ACC_SAT_EN
    ,
    output logic                 sat_flag
`endif
);

    localparam int CNT_W = cnt_width(WINDOW);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_sample;
    logic             w_last;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             r_busy;
    logic             r_drop_err;
    logic             w_sat_hit;

    // clear beats a coincident sample; the discarded sample does not count.
    assign w_sample = prodout && !clear;
    assign w_last   = w_sample && (r_count == CNT_W'(WINDOW - 1));
    assign w_ext    = ACC_W'(prodsum);

`ifdef MULTADD_ACC_SAT_EN
    logic [ACC_W:0] w_wide;
    logic           r_sat_flag;

    assign w_wide    = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_sum     = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
    assign w_sat_hit = w_sample && w_wide[ACC_W];
    assign sat_flag  = r_sat_flag;

    // Sticky saturation indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if (w_sat_hit) begin
            r_sat_flag <= 1'b1;
        end else begin
            r_sat_flag <= r_sat_flag;
        end
    end
`else
    assign w_sum     = r_acc + w_ext;
    assign w_sat_hit = 1'b0;
`endif

    // Next-state, counter and accumulator update; the final sample restarts the window.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_acc_nxt   = r_acc;
        if (clear) begin
            w_state_nxt = IDLE;
            w_count_nxt = {CNT_W{1'b0}};
            w_acc_nxt   = {ACC_W{1'b0}};
        end else if (w_last) begin
            w_state_nxt = IDLE;
            w_count_nxt = {CNT_W{1'b0}};
            w_acc_nxt   = {ACC_W{1'b0}};
        end else if (w_sample) begin
            w_state_nxt = ACCUM;
            w_count_nxt = r_count + CNT_W'(1);
            w_acc_nxt   = w_sum;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state, counter, accumulator and registered busy indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= {CNT_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
            r_busy  <= (w_state_nxt == ACCUM);
        end
    end

    // A result is lost only when the queue is full and nothing leaves this cycle.
    assign w_drop = w_last && w_full && !sum_ready;

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err <= 1'b0;
        end else if (w_drop) begin
            r_drop_err <= 1'b1;
        end else begin
            r_drop_err <= r_drop_err;
        end
    end

    assign busy     = r_busy;
    assign drop_err = r_drop_err;

    multadd_res_fifo #(
        .W (ACC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_last),
        .i_data  (w_sum),
        .i_ready (sum_ready),
        .o_data  (sum_out),
        .o_valid (sum_valid),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
